// File: rtl/tqvp_pwm_multi_if.sv
// TinyQV byte-peripheral register bus: address, write strobe, write data and read data.
interface tqvp_pwm_multi_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/tqvp_pwm_multi.sv
// Multi-channel PWM on the TinyQV byte bus: shared prescaled 8-bit timebase, edge/center
// alignment, per-channel polarity, duty and period double-buffered to the period boundary.
module tqvp_pwm_multi #(
  parameter int NCH     = 4,
  parameter int PRESC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           ui_in,
  output logic [7:0]           uo_out,
  tqvp_pwm_multi_if.slave      bus
);

  localparam logic [2:0] NCH_L = 3'(NCH);

  logic               en_q, en_d;
  logic               mode_q, mode_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         period_sh_q, period_sh_d;
  logic [NCH-1:0]     pol_q, pol_d;
  logic [7:0]         duty_sh_q [NCH];
  logic [7:0]         duty_sh_d [NCH];
  logic [7:0]         top_a_q, top_a_d;
  logic [7:0]         duty_a_q [NCH];
  logic [7:0]         duty_a_d [NCH];
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               cyc_q, cyc_d;
  logic [NCH-1:0]     uo_q, uo_d;

  logic               sync_s;
  logic               tick_s;
  logic               bnd_s;
  logic               sel_duty_s;
  logic [1:0]         didx_s;
  logic [7:0]         rdata_s;
  logic               unused_s;

  assign unused_s   = &{1'b0, ui_in};
  assign didx_s     = bus.address[1:0];
  assign sel_duty_s = (bus.address[3:2] == 2'b01) && ({1'b0, didx_s} < NCH_L);

  // Register writes, timebase advance and shadow-to-active transfer.
  always_comb begin
    en_d        = en_q;
    mode_d      = mode_q;
    presc_d     = presc_q;
    period_sh_d = period_sh_q;
    pol_d       = pol_q;
    duty_sh_d   = duty_sh_q;
    top_a_d     = top_a_q;
    duty_a_d    = duty_a_q;
    pcnt_d      = pcnt_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    cyc_d       = cyc_q;
    sync_s      = 1'b0;
    tick_s      = 1'b0;
    bnd_s       = 1'b0;

    if (bus.data_write) begin
      case (bus.address)
        4'h0: begin
          en_d   = bus.data_in[0];
          mode_d = bus.data_in[1];
          sync_s = bus.data_in[2] & bus.data_in[0];
        end
        4'h1: presc_d     = PRESC_W'(bus.data_in);
        4'h2: period_sh_d = bus.data_in;
        4'h3: pol_d       = bus.data_in[NCH-1:0];
        4'hF: cyc_d       = cyc_q & ~bus.data_in[0];
        default: begin
          if (sel_duty_s) duty_sh_d[didx_s] = bus.data_in;
          else            duty_sh_d = duty_sh_q;
        end
      endcase
    end else begin
      sync_s = 1'b0;
    end

    if (!en_q || sync_s) begin
      // Idle or resync: timebase parked at the period start, actives follow shadows.
      pcnt_d   = '0;
      cnt_d    = 8'd0;
      dir_d    = 1'b0;
      top_a_d  = period_sh_q;
      duty_a_d = duty_sh_q;
    end else begin
      tick_s = (pcnt_q == presc_q);
      pcnt_d = tick_s ? '0 : pcnt_q + PRESC_W'(1);
      if (!tick_s) begin
        cnt_d = cnt_q;
      end else if (!mode_q) begin
        bnd_s = (cnt_q == top_a_q);
        cnt_d = (cnt_q >= top_a_q) ? 8'd0 : cnt_q + 8'd1;
      end else if (top_a_q == 8'd0) begin
        bnd_s = 1'b1;
        cnt_d = 8'd0;
        dir_d = 1'b0;
      end else if (!dir_q) begin
        if (cnt_q >= top_a_q) begin
          dir_d = 1'b1;
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        if (cnt_q == 8'd0) begin
          bnd_s = 1'b1;
          dir_d = 1'b0;
          cnt_d = 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      if (bnd_s) begin
        top_a_d  = period_sh_q;
        duty_a_d = duty_sh_q;
        cyc_d    = 1'b1;
      end else begin
        top_a_d  = top_a_q;
        duty_a_d = duty_a_q;
      end
    end
  end

  // Compare stage feeding the registered outputs.
  always_comb begin
    uo_d = '0;
    for (int n = 0; n < NCH; n++) begin
      if (en_q) uo_d[n] = (cnt_q < duty_a_q[n]) ^ pol_q[n];
      else      uo_d[n] = pol_q[n];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      mode_q      <= 1'b0;
      presc_q     <= '0;
      period_sh_q <= 8'd0;
      pol_q       <= '0;
      top_a_q     <= 8'd0;
      pcnt_q      <= '0;
      cnt_q       <= 8'd0;
      dir_q       <= 1'b0;
      cyc_q       <= 1'b0;
      uo_q        <= '0;
      for (int n = 0; n < NCH; n++) begin
        duty_sh_q[n] <= 8'd0;
        duty_a_q[n]  <= 8'd0;
      end
    end else begin
      en_q        <= en_d;
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      period_sh_q <= period_sh_d;
      pol_q       <= pol_d;
      top_a_q     <= top_a_d;
      pcnt_q      <= pcnt_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      cyc_q       <= cyc_d;
      uo_q        <= uo_d;
      duty_sh_q   <= duty_sh_d;
      duty_a_q    <= duty_a_d;
    end
  end

  // Read mux.
  always_comb begin
    rdata_s = 8'h00;
    case (bus.address)
      4'h0: rdata_s = {6'b000000, mode_q, en_q};
      4'h1: rdata_s = 8'(presc_q);
      4'h2: rdata_s = period_sh_q;
      4'h3: rdata_s = 8'(pol_q);
      4'hE: rdata_s = cnt_q;
      4'hF: rdata_s = {7'b0000000, cyc_q};
      default: begin
        if (sel_duty_s) rdata_s = duty_sh_q[didx_s];
        else            rdata_s = 8'h00;
      end
    endcase
  end

  assign bus.data_out = rdata_s;
  assign uo_out       = 8'(uo_q);

endmodule

// File: tb/tb_tqvp_pwm_multi.sv
// Directed bench for tqvp_pwm_multi: edge/center PWM, buffering, prescaler, polarity, flag, sync, reset.
module tb_tqvp_pwm_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] rv;
  logic [7:0] cp [8];
  logic       e;
  int         vectors = 0;
  int         miscompares = 0;

  tqvp_pwm_multi_if bus ();

  tqvp_pwm_multi #(.NCH(4), .PRESC_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: the write lands on the next posedge, returns at the following negedge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.address    = a;
    bus.data_in    = d;
    bus.data_write = 1'b1;
    @(negedge clk);
    bus.data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    bus.address = a;
    #1;
    d = bus.data_out;
  endtask

  initial begin
    rst_n          = 1'b0;
    ui_in          = 8'hA5;
    bus.address    = 4'h0;
    bus.data_in    = 8'h00;
    bus.data_write = 1'b0;
    cp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1};

    repeat (2) @(negedge clk);
    chk("reset_uo", uo_out, 8'h00);
    rd(4'hE, rv); chk("reset_cnt", rv, 8'h00);
    rd(4'hF, rv); chk("reset_status", rv, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Edge mode, period 10, duty 3
    wr(4'h1, 8'd0); wr(4'h2, 8'd9); wr(4'h4, 8'd3); wr(4'h0, 8'h01);
    for (int i = 0; i < 20; i++) begin
      e = (i >= 1) && (((i - 1) % 10) < 3);
      chk($sformatf("edge_uo_%0d", i), {7'd0, uo_out[0]}, {7'd0, e});
      rd(4'hE, rv); chk($sformatf("edge_cnt_%0d", i), rv, 8'(i % 10));
      if (i == 9)  begin rd(4'hF, rv); chk("edge_cyc_pre", rv, 8'h00); end
      if (i == 10) begin rd(4'hF, rv); chk("edge_cyc_set", rv, 8'h01); end
      @(negedge clk);
    end

    // Duty update mid-period only affects the next period
    repeat (5) @(negedge clk);
    rd(4'hE, rv); chk("dbuf_cnt5", rv, 8'd5);
    wr(4'h4, 8'd7);
    rd(4'h4, rv); chk("dbuf_shadow_read", rv, 8'd7);
    for (int k = 26; k < 42; k++) begin
      e = (k <= 30) ? 1'b0 : (((k - 31) % 10) < 7);
      chk($sformatf("dbuf_uo_%0d", k), {7'd0, uo_out[0]}, {7'd0, e});
      @(negedge clk);
    end

    // Disable and clear the sticky flag
    wr(4'h0, 8'h00);
    wr(4'hF, 8'h01);
    rd(4'hF, rv); chk("cyc_clear", rv, 8'h00);

    // Center mode, top 4, duty1 2
    wr(4'h2, 8'd4); wr(4'h5, 8'd2); wr(4'h0, 8'h03);
    rd(4'h0, rv); chk("ctrl_read", rv, 8'h03);
    for (int k = 0; k < 18; k++) begin
      e = (k >= 1) && ((k % 8) <= 2);
      rd(4'hE, rv); chk($sformatf("ctr_cnt_%0d", k), rv, cp[k % 8]);
      chk($sformatf("ctr_uo1_%0d", k), {7'd0, uo_out[1]}, {7'd0, e});
      if (k == 8) begin rd(4'hF, rv); chk("ctr_cyc_pre", rv, 8'h00); end
      if (k == 9) begin rd(4'hF, rv); chk("ctr_cyc_set", rv, 8'h01); end
      @(negedge clk);
    end

    // Prescaler 3, period 2 ticks, duty 1
    wr(4'h0, 8'h00);
    wr(4'h1, 8'd3); wr(4'h2, 8'd1); wr(4'h4, 8'd1); wr(4'h0, 8'h01);
    for (int k = 0; k < 17; k++) begin
      e = (k >= 1) && ((((k - 1) / 4) % 2) == 0);
      rd(4'hE, rv); chk($sformatf("presc_cnt_%0d", k), rv, 8'((k / 4) % 2));
      chk($sformatf("presc_uo_%0d", k), {7'd0, uo_out[0]}, {7'd0, e});
      @(negedge clk);
    end

    // Polarity idle level and duty extremes
    wr(4'h0, 8'h00);
    wr(4'h3, 8'h01);
    @(negedge clk);
    chk("pol_idle", uo_out, 8'h01);
    wr(4'h1, 8'd0); wr(4'h4, 8'd0); wr(4'h0, 8'h01);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("duty0_uo_%0d", k), {7'd0, uo_out[0]}, 8'h01);
      @(negedge clk);
    end
    wr(4'h0, 8'h00); wr(4'h2, 8'd9); wr(4'h4, 8'hFF); wr(4'h0, 8'h01);
    @(negedge clk);
    for (int k = 1; k < 13; k++) begin
      chk($sformatf("dutyff_uo_%0d", k), {7'd0, uo_out[0]}, 8'h00);
      @(negedge clk);
    end

    // Sticky flag: clear off-boundary, then clear on a boundary (set wins)
    wr(4'hF, 8'h01);
    rd(4'hF, rv); chk("cyc_clr_offbnd", rv, 8'h00);
    repeat (5) @(negedge clk);
    rd(4'hE, rv); chk("cnt_before_bnd", rv, 8'd9);
    wr(4'hF, 8'h01);
    rd(4'hF, rv); chk("cyc_set_wins", rv, 8'h01);
    wr(4'hF, 8'h01);
    rd(4'hF, rv); chk("cyc_clr_after", rv, 8'h00);

    // SYNC restarts the timebase
    rd(4'hE, rv); chk("cnt_before_sync", rv, 8'd1);
    wr(4'h0, 8'h05);
    rd(4'hE, rv); chk("sync_cnt0", rv, 8'd0);
    rd(4'h0, rv); chk("sync_reads0", rv, 8'h01);
    @(negedge clk);
    rd(4'hE, rv); chk("sync_cnt1", rv, 8'd1);

    // Reset in the middle of a high pulse
    wr(4'h3, 8'h00); wr(4'h4, 8'd3); wr(4'h0, 8'h05);
    @(negedge clk);
    chk("pulse_high", uo_out, 8'h03);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_uo", uo_out, 8'h00);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), rv); chk($sformatf("rst_reg_%0d", a), rv, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
